// File: rtl/tile_mover.sv
// tile_mover: moves one TILE x TILE sprite across a tile map, one frame at a time.
// A frame update starts on frame_stb. It probes the map for the pending turn request,
// probes again for the current heading, then moves the sprite by a fraction of a pixel
// (speed/256 px per frame). The map is a synchronous ROM outside this block.
//
// Ports:
//   vga_pix_clk   - sole clock
//   rst           - asynchronous, active-high reset
//   frame_stb     - one-cycle frame pulse; starts an update when idle and enabled
//   enable        - 0 = frame_stb is ignored
//   dir_req_valid - strobe: dir_req is loaded as the pending turn request
//   dir_req       - requested direction (0=UP 1=RIGHT 2=LEFT 3=DOWN)
//   speed         - pixels per frame in 1/256 units (0..256)
//   tile_addr     - map read address (row*MAP_W_TILES+col), combinational
//   tile_data     - map word for the previous cycle's tile_addr; nonzero = wall
//   x_pos, y_pos  - sprite top-left pixel
//   cur_dir       - current heading
//   blocked       - last frame's move was stopped by a wall
//   step_done     - one-cycle pulse; the frame update is complete and visible
//   overrun       - sticky; a frame_stb arrived while an update was in progress
//
// Strobe semantics: frame_stb and dir_req_valid are single-cycle strobes with no
// back-pressure. A frame_stb that arrives while busy is dropped and flagged on overrun.
// dir_req_valid is always taken, and the latest request replaces any earlier one.
module tile_mover #(
    parameter int MAP_W_TILES = 32,
    parameter int MAP_H_TILES = 36,
    parameter int TILE        = 8,
    parameter int POS_W       = 9,
    parameter int START_X     = 8,
    parameter int START_Y     = 32,
    parameter int START_DIR   = 1,
    parameter int BUF_FRAMES  = 8,
    localparam int ADDR_W     = $clog2(MAP_W_TILES * MAP_H_TILES)
) (
    input  logic              vga_pix_clk,
    input  logic              rst,
    input  logic              frame_stb,
    input  logic              enable,
    input  logic              dir_req_valid,
    input  logic [1:0]        dir_req,
    input  logic [8:0]        speed,
    output logic [ADDR_W-1:0] tile_addr,
    input  logic [3:0]        tile_data,
    output logic [POS_W-1:0]  x_pos,
    output logic [POS_W-1:0]  y_pos,
    output logic [1:0]        cur_dir,
    output logic              blocked,
    output logic              step_done,
    output logic              overrun
);

    localparam int TSH    = $clog2(TILE);
    localparam int PW     = POS_W + 1;    // one spare bit for probe arithmetic
    localparam int X_SPAN = MAP_W_TILES * TILE;
    localparam int CNT_W  = (BUF_FRAMES > 0) ? $clog2(BUF_FRAMES + 1) : 1;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    localparam logic [PW-1:0]    P_ONE   = PW'(1);
    localparam logic [PW-1:0]    P_TILE  = PW'(TILE);
    localparam logic [PW-1:0]    P_XSPAN = PW'(X_SPAN);
    localparam logic [PW-1:0]    P_H     = PW'(MAP_H_TILES);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
    localparam logic [POS_W-1:0] X_LAST  = POS_W'(X_SPAN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, REQ_RD, REQ_CHK, CUR_RD, CUR_CHK} state_t;
    state_t state;

    logic             pend_valid;
    logic [1:0]       pend_dir;
    logic [CNT_W-1:0] exp_cnt;
    logic [7:0]       acc;
    logic             oob_q;       // the probe issued last cycle fell outside the map rows
    logic [1:0]       req_dir_q;   // pending direction that was actually probed
    logic             accepted_q;  // a turn was taken this frame

    // Probe pixel and map address
    logic [1:0]    probe_dir;
    logic [PW-1:0] px, py, probe_col, probe_row;
    logic          probe_oob;

    always_comb begin
        probe_dir = (state == REQ_RD) ? pend_dir : cur_dir;
        px        = PW'(x_pos);
        py        = PW'(y_pos);
        probe_oob = 1'b0;
        case (probe_dir)
            DIR_UP: begin
                if (y_pos == '0) probe_oob = 1'b1;
                else             py = PW'(y_pos) - P_ONE;
            end
            DIR_DOWN: py = PW'(y_pos) + P_TILE;
            DIR_LEFT: px = (x_pos == '0) ? (P_XSPAN - P_ONE) : (PW'(x_pos) - P_ONE);
            default: begin
                px = PW'(x_pos) + P_TILE;
                if (px >= P_XSPAN) px = px - P_XSPAN;  // columns wrap horizontally
            end
        endcase
        probe_col = px >> TSH;
        probe_row = py >> TSH;
        if (probe_row >= P_H) probe_oob = 1'b1;
        tile_addr = probe_oob ? '0
                  : ADDR_W'(probe_row) * ADDR_W'(MAP_W_TILES) + ADDR_W'(probe_col);
    end

    // Data arriving this cycle belongs to last cycle's probe; off-map rows count as wall.
    logic wall;
    assign wall = oob_q || (tile_data != 4'd0);

    // Alignment is measured on the axis the sprite is currently moving along.
    logic cur_horiz, aligned;
    assign cur_horiz = cur_dir[0] ^ cur_dir[1];
    assign aligned   = cur_horiz ? (x_pos[TSH-1:0] == '0) : (y_pos[TSH-1:0] == '0);

    // Opposite pairs (0/3, 1/2) are bitwise complements of each other.
    logic req_same, req_opp, req_ok;
    assign req_same = (pend_dir == cur_dir);
    assign req_opp  = (pend_dir == ~cur_dir);
    assign req_ok   = !req_same && !wall && (req_opp || aligned);

    logic [9:0] sum;
    logic       step;
    assign sum  = {2'b00, acc} + {1'b0, speed};
    assign step = |sum[9:8];

    always_ff @(posedge vga_pix_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            x_pos      <= POS_W'(START_X);
            y_pos      <= POS_W'(START_Y);
            cur_dir    <= 2'(START_DIR);
            pend_valid <= 1'b0;
            pend_dir   <= DIR_UP;
            exp_cnt    <= '0;
            acc        <= '0;
            oob_q      <= 1'b0;
            req_dir_q  <= DIR_UP;
            accepted_q <= 1'b0;
            blocked    <= 1'b0;
            step_done  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            step_done <= 1'b0;
            if (frame_stb && enable && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (frame_stb && enable) state <= REQ_RD;
                REQ_RD: begin
                    oob_q     <= probe_oob;
                    req_dir_q <= pend_dir;
                    state     <= REQ_CHK;
                end
                REQ_CHK: begin
                    accepted_q <= 1'b0;
                    // A request replaced during REQ_RD was not probed; it waits a frame.
                    if (pend_valid && pend_dir == req_dir_q) begin
                        if (req_same) begin
                            pend_valid <= 1'b0;
                        end else if (req_ok) begin
                            cur_dir    <= pend_dir;
                            pend_valid <= 1'b0;
                            accepted_q <= 1'b1;
                        end
                    end
                    state <= CUR_RD;
                end
                CUR_RD: begin
                    oob_q <= probe_oob;
                    state <= CUR_CHK;
                end
                CUR_CHK: begin
                    if (aligned && wall) begin
                        blocked <= 1'b1;
                    end else begin
                        blocked <= 1'b0;
                        acc     <= sum[7:0];
                        if (step) begin
                            case (cur_dir)
                                DIR_UP:   y_pos <= y_pos - POS_ONE;
                                DIR_DOWN: y_pos <= y_pos + POS_ONE;
                                DIR_LEFT: x_pos <= (x_pos == '0) ? X_LAST : x_pos - POS_ONE;
                                default:  x_pos <= (x_pos == X_LAST) ? '0 : x_pos + POS_ONE;
                            endcase
                        end
                    end
                    if (BUF_FRAMES > 0 && pend_valid && !accepted_q) begin
                        if (exp_cnt <= CNT_ONE) begin
                            exp_cnt    <= '0;
                            pend_valid <= 1'b0;
                        end else begin
                            exp_cnt <= exp_cnt - CNT_ONE;
                        end
                    end
                    step_done <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A fresh request overrides any clear/expiry decided above in the same cycle.
            if (dir_req_valid) begin
                pend_valid <= 1'b1;
                pend_dir   <= dir_req;
                exp_cnt    <= CNT_W'(BUF_FRAMES);
            end
        end
    end

endmodule

// File: tb/tb_tile_mover.sv
// Testbench for tile_mover: a directed frame sequence with hand-computed positions.
// Each issued frame pushes its expected result and its step_done cycle onto exp_q.
// A negedge monitor pops an entry whenever step_done is high and compares it.
module tb_tile_mover;

    localparam int EW = 53;  // {x[8:0], y[8:0], dir[1:0], blocked, cycle[31:0]}

    logic        vga_pix_clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_stb = 1'b0;
    logic        enable = 1'b0;
    logic        dir_req_valid = 1'b0;
    logic [1:0]  dir_req = 2'd0;
    logic [8:0]  speed = 9'd0;
    logic [10:0] tile_addr;
    logic [3:0]  tile_data = 4'd0;
    logic [8:0]  x_pos, y_pos;
    logic [1:0]  cur_dir;
    logic        blocked, step_done, overrun;

    logic [3:0]    map_mem [0:2047];
    logic [31:0]   cyc = 32'd0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_e, act_e;
    int            vec_cnt = 0;
    int            err_cnt = 0;
    int            sd_count = 0;
    int            frame_no = 0;

    tile_mover #(.BUF_FRAMES(4)) dut (
        .vga_pix_clk  (vga_pix_clk),
        .rst          (rst),
        .frame_stb    (frame_stb),
        .enable       (enable),
        .dir_req_valid(dir_req_valid),
        .dir_req      (dir_req),
        .speed        (speed),
        .tile_addr    (tile_addr),
        .tile_data    (tile_data),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .cur_dir      (cur_dir),
        .blocked      (blocked),
        .step_done    (step_done),
        .overrun      (overrun)
    );

    // ---------------- clock / reset / map ROM ----------------
    always #5 vga_pix_clk = ~vga_pix_clk;

    always @(posedge vga_pix_clk) begin
        cyc       <= cyc + 32'd1;
        tile_data <= map_mem[tile_addr];
    end

    task automatic reset_dut();
        @(negedge vga_pix_clk);
        rst = 1'b1;
        repeat (3) @(negedge vga_pix_clk);
        rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_exp(input logic [8:0] ex, input logic [8:0] ey,
                            input logic [1:0] ed, input logic eb);
        exp_q.push_back({ex, ey, ed, eb, cyc + 32'd5});
    endtask

    // One frame, 10 cycles long; the DUT must answer 5 cycles after the strobe.
    task automatic frame(input logic [8:0] ex, input logic [8:0] ey,
                         input logic [1:0] ed, input logic eb);
        @(negedge vga_pix_clk);
        frame_stb = 1'b1;
        push_exp(ex, ey, ed, eb);
        @(negedge vga_pix_clk);
        frame_stb = 1'b0;
        repeat (8) @(negedge vga_pix_clk);
    endtask

    task automatic request(input logic [1:0] d);
        @(negedge vga_pix_clk);
        dir_req_valid = 1'b1;
        dir_req       = d;
        @(negedge vga_pix_clk);
        dir_req_valid = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge vga_pix_clk) begin
        if (step_done === 1'b1) sd_count++;
        if (!rst && step_done === 1'b1) begin
            frame_no++;
            vec_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL unexpected_step_done: cycle %0d x=%0d y=%0d, expected no pulse",
                         cyc, x_pos, y_pos);
            end else begin
                exp_e = exp_q.pop_front();
                act_e = {x_pos, y_pos, cur_dir, blocked, cyc};
                if (act_e !== exp_e) begin
                    err_cnt++;
                    $display("FAIL frame_%0d: got x=%0d y=%0d dir=%0d blk=%0d cyc=%0d, expected x=%0d y=%0d dir=%0d blk=%0d cyc=%0d",
                             frame_no, x_pos, y_pos, cur_dir, blocked, cyc,
                             exp_e[52:44], exp_e[43:35], exp_e[34:33], exp_e[32], exp_e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int base;

    initial begin
        for (int i = 0; i < 2048; i++) map_mem[i] = 4'd0;
        map_mem[4*32 + 3]  = 4'd1;  // wall at col 3, row 4
        map_mem[3*32 + 31] = 4'd1;  // row 3 col 31: a probe that forgets to wrap lands here

        reset_dut();
        check("rst_x", 32'(x_pos), 8);
        check("rst_y", 32'(y_pos), 32);
        check("rst_dir", 32'(cur_dir), 1);
        check("rst_blocked", 32'(blocked), 0);
        check("rst_step_done", 32'(step_done), 0);
        check("rst_overrun", 32'(overrun), 0);

        // Open row 4, full speed: one pixel per frame, then a wall at col 3.
        enable = 1'b1;
        speed  = 9'd256;
        for (int i = 9; i <= 16; i++) frame(9'(i), 9'd32, 2'd1, 1'b0);
        frame(9'd16, 9'd32, 2'd1, 1'b1);
        frame(9'd16, 9'd32, 2'd1, 1'b1);

        // enable low: the strobe is ignored.
        base = sd_count;
        enable = 1'b0;
        frame_stb = 1'b1;
        @(negedge vga_pix_clk);
        frame_stb = 1'b0;
        repeat (9) @(negedge vga_pix_clk);
        check("disabled_no_step_done", 32'(sd_count - base), 0);
        check("disabled_x", 32'(x_pos), 16);
        enable = 1'b1;

        // Reset in the middle of a frame aborts it.
        base = sd_count;
        @(negedge vga_pix_clk);
        frame_stb = 1'b1;
        @(negedge vga_pix_clk);
        frame_stb = 1'b0;
        @(negedge vga_pix_clk);
        rst = 1'b1;
        @(negedge vga_pix_clk);
        rst = 1'b0;
        repeat (8) @(negedge vga_pix_clk);
        check("midframe_rst_no_step_done", 32'(sd_count - base), 0);
        check("midframe_rst_x", 32'(x_pos), 8);
        check("midframe_rst_blocked", 32'(blocked), 0);

        // UP requested at x=13: held until x=16, then the sprite climbs to the top edge.
        for (int i = 9; i <= 13; i++) frame(9'(i), 9'd32, 2'd1, 1'b0);
        request(2'd0);
        for (int i = 14; i <= 16; i++) frame(9'(i), 9'd32, 2'd1, 1'b0);
        for (int yy = 31; yy >= 0; yy--) frame(9'd16, 9'(yy), 2'd0, 1'b0);
        frame(9'd16, 9'd0, 2'd0, 1'b1);  // row -1 is off the map: wall

        // Reversal at an unaligned x, then the left-edge wrap.
        reset_dut();
        for (int i = 9; i <= 13; i++) frame(9'(i), 9'd32, 2'd1, 1'b0);
        request(2'd2);
        for (int i = 12; i >= 0; i--) frame(9'(i), 9'd32, 2'd2, 1'b0);
        frame(9'd255, 9'd32, 2'd2, 1'b0);
        frame(9'd254, 9'd32, 2'd2, 1'b0);

        // Half speed: a step every second frame.
        speed = 9'd128;
        frame(9'd254, 9'd32, 2'd2, 1'b0);
        frame(9'd253, 9'd32, 2'd2, 1'b0);
        frame(9'd253, 9'd32, 2'd2, 1'b0);
        frame(9'd252, 9'd32, 2'd2, 1'b0);
        speed = 9'd0;
        frame(9'd252, 9'd32, 2'd2, 1'b0);
        frame(9'd252, 9'd32, 2'd2, 1'b0);

        // Expiry: UP blocked for 4 frames, then the wall is removed; no turn follows.
        reset_dut();
        map_mem[3*32 + 1] = 4'd1;
        request(2'd0);
        for (int i = 0; i < 4; i++) frame(9'd8, 9'd32, 2'd1, 1'b0);
        map_mem[3*32 + 1] = 4'd0;
        frame(9'd8, 9'd32, 2'd1, 1'b0);
        frame(9'd8, 9'd32, 2'd1, 1'b0);

        // A second strobe while the first frame is in CUR_RD sets overrun.
        check("overrun_before", 32'(overrun), 0);
        @(negedge vga_pix_clk);
        frame_stb = 1'b1;
        push_exp(9'd8, 9'd32, 2'd1, 1'b0);
        @(negedge vga_pix_clk);
        frame_stb = 1'b0;
        @(negedge vga_pix_clk);
        @(negedge vga_pix_clk);
        frame_stb = 1'b1;
        @(negedge vga_pix_clk);
        frame_stb = 1'b0;
        repeat (10) @(negedge vga_pix_clk);
        check("overrun_after", 32'(overrun), 1);

        repeat (10) @(negedge vga_pix_clk);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
